rxpy_bytebuf: RTL and testbench

- Downstream of the payload bit processor, on the receive path.
- Takes the serial decoded payload bit stream after FEC 2/3 decode and de-whitening, strobed once per valid data bit.
- Discards the payload header bits, packs payload data bits LSB-first into bytes and pushes them into a FIFO for the link controller / host to read.
- At end of payload, reports the completed byte count and the CRC status.

---
 rtl/rxpy_bytebuf_if.sv | 38 +++
 rtl/rxpy_bytebuf.sv | 157 +++++++++++++++
 tb/tb_rxpy_bytebuf.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rxpy_bytebuf_if.sv
// Port bundle for the receive payload byte buffer: decoder-side bit stream
// in, host-side FIFO read and packet status out.
interface rxpy_bytebuf_if #(
  parameter int unsigned AW = 5
);
  logic          rx_st_p;
  logic          rx_bit_valid;
  logic          rx_bit;
  logic [1:0]    hdr_bytes;
  logic [9:0]    dec_pylenByte;
  logic [9:0]    fixed_len;
  logic          rx_end_p;
  logic          dec_crcgood;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rd_empty;
  logic [AW:0]   fifo_count;
  logic [9:0]    pkt_bytes;
  logic          pkt_done;
  logic          pkt_crcgood;
  logic          overflow;

  // Driver side: payload decoder plus host reader
  modport master (
    output rx_st_p, rx_bit_valid, rx_bit, hdr_bytes, dec_pylenByte, fixed_len,
           rx_end_p, dec_crcgood, rd_en,
    input  rd_data, rd_empty, fifo_count, pkt_bytes, pkt_done, pkt_crcgood,
           overflow
  );

  // Byte buffer side
  modport slave (
    input  rx_st_p, rx_bit_valid, rx_bit, hdr_bytes, dec_pylenByte, fixed_len,
           rx_end_p, dec_crcgood, rd_en,
    output rd_data, rd_empty, fifo_count, pkt_bytes, pkt_done, pkt_crcgood,
           overflow
  );
endinterface

// File: rtl/rxpy_bytebuf.sv
// Receive payload byte buffer: strips header bits, packs data bits LSB-first
// into bytes, queues them in a FWFT FIFO and reports byte count / CRC status.
module rxpy_bytebuf #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic           clk_6M,
  input  logic           rst,
  rxpy_bytebuf_if.slave  bus
);

  localparam int unsigned CW      = AW + 1;
  localparam logic [9:0]  LEN_MAX = 10'd1021;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [4:0]      bitcnt_q;
  logic [7:0]      shreg_q;
  logic [9:0]      len_q;
  logic [9:0]      bytecnt_q;
  logic [1:0]      hdr_q;
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q;
  logic [9:0]      pkt_bytes_q;
  logic            pkt_done_q;
  logic            crc_q;
  logic            overflow_q;
  logic [7:0]      mem_q [DEPTH];

  logic            clr_c, end_acc_c, hdr_strobe_c, hdr_last_c;
  logic            shift_c, wr_req_c, last_byte_c;
  logic            full_c, rd_ok_c, wr_ok_c, drop_c;
  logic [7:0]      byte_c;
  logic [9:0]      hdr_len_c, fix_len_c;

  function automatic logic [9:0] clamp_len(input logic [9:0] x);
    return (x > LEN_MAX) ? LEN_MAX : x;
  endfunction

  always_ff @(posedge clk_6M or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Event decode; rx_st_p beats rx_end_p, which beats a bit strobe
  always_comb begin
    clr_c        = bus.rx_st_p;
    end_acc_c    = 1'b0;
    hdr_strobe_c = 1'b0;
    shift_c      = 1'b0;
    hdr_last_c   = (bitcnt_q == ({hdr_q, 3'b000} - 5'd1));
    last_byte_c  = (bytecnt_q == (len_q - 10'd1));
    if (!clr_c) begin
      end_acc_c    = bus.rx_end_p &&
                     ((state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_DRAIN));
      hdr_strobe_c = !bus.rx_end_p && bus.rx_bit_valid && (state_q == S_HDR);
      shift_c      = !bus.rx_end_p && bus.rx_bit_valid && (state_q == S_DATA);
    end
    wr_req_c = shift_c && (bitcnt_q[2:0] == 3'd7);
  end

  always_comb begin
    state_d = state_q;
    if (clr_c) begin
      state_d = (bus.hdr_bytes != 2'd0) ? S_HDR : S_DATA;
    end else if (end_acc_c) begin
      state_d = S_DONE;
    end else begin
      case (state_q)
        S_HDR:   if (hdr_strobe_c && hdr_last_c)
                   state_d = (hdr_len_c == 10'd0) ? S_DRAIN : S_DATA;
        S_DATA:  if (wr_req_c && last_byte_c) state_d = S_DRAIN;
        default: state_d = state_q;
      endcase
    end
  end

  assign hdr_len_c = clamp_len(bus.dec_pylenByte);
  assign fix_len_c = clamp_len(bus.fixed_len);
  assign byte_c    = {bus.rx_bit, shreg_q[7:1]};
  assign full_c    = (count_q == CW'(DEPTH));
  assign rd_ok_c   = bus.rd_en && (count_q != '0) && !clr_c;
  assign wr_ok_c   = wr_req_c && (!full_c || bus.rd_en);
  assign drop_c    = wr_req_c && full_c && !bus.rd_en;

  always_ff @(posedge clk_6M or posedge rst) begin
    if (rst) begin
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      len_q       <= '0;
      bytecnt_q   <= '0;
      hdr_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      pkt_bytes_q <= '0;
      pkt_done_q  <= 1'b0;
      crc_q       <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (clr_c) begin
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      len_q       <= (bus.hdr_bytes == 2'd0) ? fix_len_c : 10'd0;
      bytecnt_q   <= '0;
      hdr_q       <= bus.hdr_bytes;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      pkt_bytes_q <= '0;
      pkt_done_q  <= 1'b0;
      crc_q       <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      pkt_done_q <= end_acc_c;
      if (end_acc_c) begin
        crc_q    <= bus.dec_crcgood;
        bitcnt_q <= '0;
        shreg_q  <= '0;
      end
      if (hdr_strobe_c) begin
        bitcnt_q <= hdr_last_c ? 5'd0 : bitcnt_q + 5'd1;
        if (hdr_last_c) len_q <= hdr_len_c;
      end
      if (shift_c) begin
        shreg_q  <= byte_c;
        bitcnt_q <= 5'(bitcnt_q[2:0] + 3'd1);
      end
      if (wr_req_c) bytecnt_q <= bytecnt_q + 10'd1;
      if (wr_ok_c) wptr_q <= wptr_q + AW'(1);
      if (rd_ok_c) rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + CW'(wr_ok_c) - CW'(rd_ok_c);
      if (wr_ok_c && (pkt_bytes_q != LEN_MAX)) pkt_bytes_q <= pkt_bytes_q + 10'd1;
      if (drop_c) overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset: reads are masked while empty
  always_ff @(posedge clk_6M) begin
    if (wr_ok_c) mem_q[wptr_q] <= byte_c;
  end

  assign bus.rd_empty    = (count_q == '0);
  assign bus.rd_data     = (count_q == '0) ? 8'h00 : mem_q[rptr_q];
  assign bus.fifo_count  = count_q;
  assign bus.pkt_bytes   = pkt_bytes_q;
  assign bus.pkt_done    = pkt_done_q;
  assign bus.pkt_crcgood = crc_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_rxpy_bytebuf.sv
// Directed bench for rxpy_bytebuf: header stripping, byte packing, FIFO
// overflow/read interplay, length clamp, early end and abort/reset.
module tb_rxpy_bytebuf;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  rxpy_bytebuf_if #(.AW(5)) bus ();
  rxpy_bytebuf #(.DEPTH(32), .AW(5)) dut (.clk_6M(clk), .rst(rst), .bus(bus));

  always #83 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.rx_bit_valid = 1'b1;
    bus.rx_bit       = b;
    cycle();
    bus.rx_bit_valid = 1'b0;
    bus.rx_bit       = 1'b0;
  endtask

  // Last bit optionally paired with rd_en
  task automatic send_byte(input logic [7:0] v, input logic rd);
    for (int i = 0; i < 7; i++) send_bit(v[i]);
    bus.rd_en = rd;
    send_bit(v[7]);
    bus.rd_en = 1'b0;
  endtask

  task automatic start_pkt(input logic [1:0] h, input logic [9:0] fl, input logic [9:0] dl);
    bus.hdr_bytes     = h;
    bus.fixed_len     = fl;
    bus.dec_pylenByte = dl;
    bus.rx_st_p       = 1'b1;
    cycle();
    bus.rx_st_p       = 1'b0;
  endtask

  task automatic end_pkt(input logic crc);
    bus.rx_end_p    = 1'b1;
    bus.dec_crcgood = crc;
    cycle();
    bus.rx_end_p    = 1'b0;
    bus.dec_crcgood = 1'b0;
  endtask

  task automatic pop();
    bus.rd_en = 1'b1;
    cycle();
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(); cycle();
    tests_run++;
    if (bus.rd_empty !== 1'b1 || bus.fifo_count !== 6'd0 || bus.rd_data !== 8'h00 ||
        bus.pkt_bytes !== 10'd0 || bus.pkt_done !== 1'b0 || bus.pkt_crcgood !== 1'b0 ||
        bus.overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: empty=%b count=%0d data=%h bytes=%0d done=%b crc=%b ovf=%b",
               bus.rd_empty, bus.fifo_count, bus.rd_data, bus.pkt_bytes, bus.pkt_done,
               bus.pkt_crcgood, bus.overflow);
    end
    rst = 1'b0;
    cycle();
    end_pkt(1'b1);
    tests_run++;
    if (bus.pkt_done !== 1'b0 || bus.pkt_crcgood !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_end_ignored: done=%b crc=%b required 0 0", bus.pkt_done, bus.pkt_crcgood);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp [3];
    exp[0] = 8'hA5; exp[1] = 8'h3C; exp[2] = 8'h81;
    start_pkt(2'd1, 10'd0, 10'd3);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    tests_run++;
    if (bus.rd_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL hdr_not_stored: empty=%b required 1", bus.rd_empty);
    end
    for (int i = 0; i < 3; i++) send_byte(exp[i], 1'b0);
    for (int i = 0; i < 16; i++) send_bit(i[0]);
    tests_run++;
    if (bus.fifo_count !== 6'd3 || bus.pkt_bytes !== 10'd3) begin
      tests_failed++;
      $display("FAIL basic_count: count=%0d bytes=%0d required 3 3", bus.fifo_count, bus.pkt_bytes);
    end
    tests_run++;
    if (bus.pkt_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done_early: done=%b required 0", bus.pkt_done);
    end
    end_pkt(1'b1);
    tests_run++;
    if (bus.pkt_done !== 1'b1 || bus.pkt_crcgood !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_done: done=%b crc=%b required 1 1", bus.pkt_done, bus.pkt_crcgood);
    end
    cycle();
    tests_run++;
    if (bus.pkt_done !== 1'b0 || bus.pkt_crcgood !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_done_width: done=%b crc=%b required 0 1", bus.pkt_done, bus.pkt_crcgood);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (bus.rd_data !== exp[i]) begin
        tests_failed++;
        $display("FAIL basic_read%0d: got %h required %h", i, bus.rd_data, exp[i]);
      end
      pop();
    end
    pop();
    tests_run++;
    if (bus.rd_empty !== 1'b1 || bus.fifo_count !== 6'd0 || bus.rd_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL basic_empty: empty=%b count=%0d data=%h required 1 0 00",
               bus.rd_empty, bus.fifo_count, bus.rd_data);
    end
  endtask

  task automatic test_fhs();
    start_pkt(2'd0, 10'd18, 10'd0);
    for (int i = 0; i < 18; i++) send_byte(8'(i * 13 + 5), 1'b0);
    for (int i = 0; i < 16; i++) send_bit(1'b1);
    end_pkt(1'b0);
    tests_run++;
    if (bus.fifo_count !== 6'd18 || bus.pkt_bytes !== 10'd18 || bus.pkt_crcgood !== 1'b0 ||
        bus.pkt_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL fhs_status: count=%0d bytes=%0d crc=%b done=%b required 18 18 0 1",
               bus.fifo_count, bus.pkt_bytes, bus.pkt_crcgood, bus.pkt_done);
    end
    for (int i = 0; i < 18; i++) begin
      tests_run++;
      if (bus.rd_data !== 8'(i * 13 + 5)) begin
        tests_failed++;
        $display("FAIL fhs_read%0d: got %h required %h", i, bus.rd_data, 8'(i * 13 + 5));
      end
      pop();
    end
  endtask

  task automatic test_overflow();
    start_pkt(2'd0, 10'd40, 10'd0);
    for (int i = 0; i < 40; i++) send_byte(8'(i), 1'b0);
    tests_run++;
    if (bus.fifo_count !== 6'd32 || bus.overflow !== 1'b1 || bus.pkt_bytes !== 10'd32) begin
      tests_failed++;
      $display("FAIL ovf_drop: count=%0d ovf=%b bytes=%0d required 32 1 32",
               bus.fifo_count, bus.overflow, bus.pkt_bytes);
    end
    for (int i = 0; i < 32; i++) begin
      tests_run++;
      if (bus.rd_data !== 8'(i)) begin
        tests_failed++;
        $display("FAIL ovf_read%0d: got %h required %h", i, bus.rd_data, 8'(i));
      end
      pop();
    end
    start_pkt(2'd0, 10'd40, 10'd0);
    for (int i = 0; i < 40; i++) begin
      if (i >= 32) begin
        tests_run++;
        if (bus.rd_data !== 8'(i - 32)) begin
          tests_failed++;
          $display("FAIL full_rdwr_head%0d: got %h required %h", i, bus.rd_data, 8'(i - 32));
        end
      end
      send_byte(8'(i), i >= 32);
    end
    tests_run++;
    if (bus.fifo_count !== 6'd32 || bus.overflow !== 1'b0 || bus.pkt_bytes !== 10'd40) begin
      tests_failed++;
      $display("FAIL full_rdwr: count=%0d ovf=%b bytes=%0d required 32 0 40",
               bus.fifo_count, bus.overflow, bus.pkt_bytes);
    end
    for (int i = 8; i < 40; i++) begin
      tests_run++;
      if (bus.rd_data !== 8'(i)) begin
        tests_failed++;
        $display("FAIL full_rdwr_read%0d: got %h required %h", i, bus.rd_data, 8'(i));
      end
      pop();
    end
  endtask

  task automatic test_clamp();
    start_pkt(2'd2, 10'd0, 10'd1023);
    for (int i = 0; i < 16; i++) send_bit(1'b0);
    for (int i = 0; i < 1021; i++) send_byte(8'(i), 1'b1);
    tests_run++;
    if (bus.pkt_bytes !== 10'd1021 || bus.fifo_count !== 6'd1 || bus.rd_data !== 8'hFC) begin
      tests_failed++;
      $display("FAIL clamp_fill: bytes=%0d count=%0d data=%h required 1021 1 fc",
               bus.pkt_bytes, bus.fifo_count, bus.rd_data);
    end
    send_byte(8'h55, 1'b0);
    tests_run++;
    if (bus.pkt_bytes !== 10'd1021 || bus.fifo_count !== 6'd1) begin
      tests_failed++;
      $display("FAIL clamp_drain: bytes=%0d count=%0d required 1021 1", bus.pkt_bytes, bus.fifo_count);
    end
    end_pkt(1'b1);
    start_pkt(2'd2, 10'd0, 10'd0);
    for (int i = 0; i < 16; i++) send_bit(1'b1);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    tests_run++;
    if (bus.rd_empty !== 1'b1 || bus.fifo_count !== 6'd0 || bus.pkt_bytes !== 10'd0) begin
      tests_failed++;
      $display("FAIL len_zero: empty=%b count=%0d bytes=%0d required 1 0 0",
               bus.rd_empty, bus.fifo_count, bus.pkt_bytes);
    end
    end_pkt(1'b1);
    tests_run++;
    if (bus.pkt_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL len_zero_done: done=%b required 1", bus.pkt_done);
    end
  endtask

  task automatic test_partial();
    logic [7:0] nib;
    nib = 8'h0F;
    start_pkt(2'd0, 10'd5, 10'd0);
    send_byte(8'h5A, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(nib[i]);
    end_pkt(1'b1);
    tests_run++;
    if (bus.pkt_bytes !== 10'd1 || bus.fifo_count !== 6'd1 || bus.pkt_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL partial_end: bytes=%0d count=%0d done=%b required 1 1 1",
               bus.pkt_bytes, bus.fifo_count, bus.pkt_done);
    end
    send_byte(8'h77, 1'b0);
    end_pkt(1'b0);
    tests_run++;
    if (bus.fifo_count !== 6'd1 || bus.pkt_done !== 1'b0 || bus.pkt_crcgood !== 1'b1) begin
      tests_failed++;
      $display("FAIL done_hold: count=%0d done=%b crc=%b required 1 0 1",
               bus.fifo_count, bus.pkt_done, bus.pkt_crcgood);
    end
    tests_run++;
    if (bus.rd_data !== 8'h5A) begin
      tests_failed++;
      $display("FAIL partial_read: got %h required 5a", bus.rd_data);
    end
    pop();
  endtask

  task automatic test_abort();
    start_pkt(2'd0, 10'd34, 10'd0);
    for (int i = 0; i < 34; i++) send_byte(8'(i + 100), 1'b0);
    send_bit(1'b1);
    bus.rd_en = 1'b1;
    start_pkt(2'd1, 10'd0, 10'd2);
    bus.rd_en = 1'b0;
    tests_run++;
    if (bus.rd_empty !== 1'b1 || bus.fifo_count !== 6'd0 || bus.overflow !== 1'b0 ||
        bus.pkt_bytes !== 10'd0) begin
      tests_failed++;
      $display("FAIL abort_clear: empty=%b count=%0d ovf=%b bytes=%0d required 1 0 0 0",
               bus.rd_empty, bus.fifo_count, bus.overflow, bus.pkt_bytes);
    end
    for (int i = 0; i < 8; i++) send_bit(1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    end_pkt(1'b1);
    tests_run++;
    if (bus.pkt_bytes !== 10'd2 || bus.fifo_count !== 6'd2 || bus.rd_data !== 8'h12) begin
      tests_failed++;
      $display("FAIL abort_new_pkt: bytes=%0d count=%0d data=%h required 2 2 12",
               bus.pkt_bytes, bus.fifo_count, bus.rd_data);
    end
    pop();
    tests_run++;
    if (bus.rd_data !== 8'h34) begin
      tests_failed++;
      $display("FAIL abort_second: got %h required 34", bus.rd_data);
    end
  endtask

  task automatic test_rst_mid();
    start_pkt(2'd0, 10'd8, 10'd0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'h3C, 1'b0);
    end_pkt(1'b1);
    #20 rst = 1'b1;
    #1;
    tests_run++;
    if (bus.rd_empty !== 1'b1 || bus.fifo_count !== 6'd0 || bus.pkt_bytes !== 10'd0 ||
        bus.pkt_done !== 1'b0 || bus.pkt_crcgood !== 1'b0 || bus.overflow !== 1'b0 ||
        bus.rd_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL rst_async: empty=%b count=%0d bytes=%0d done=%b crc=%b ovf=%b data=%h",
               bus.rd_empty, bus.fifo_count, bus.pkt_bytes, bus.pkt_done, bus.pkt_crcgood,
               bus.overflow, bus.rd_data);
    end
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  initial begin
    bus.rx_st_p = 1'b0; bus.rx_bit_valid = 1'b0; bus.rx_bit = 1'b0;
    bus.hdr_bytes = 2'd0; bus.dec_pylenByte = 10'd0; bus.fixed_len = 10'd0;
    bus.rx_end_p = 1'b0; bus.dec_crcgood = 1'b0; bus.rd_en = 1'b0;
    test_reset();
    test_basic();
    test_fhs();
    test_overflow();
    test_clamp();
    test_partial();
    test_abort();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
